// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-cycle controller: states, opcodes,
// control-word bit indices and ALU operation codes.
package cpu_pkg;

  localparam int unsigned CW_MAX = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_F1,
    ST_F2,
    ST_F3,
    ST_DEC,
    ST_E1,
    ST_E2,
    ST_E3,
    ST_HALT
  } state_t;

  // Opcode values carried in IR.op
  localparam int unsigned OP_LOAD   = 1;
  localparam int unsigned OP_STORE  = 2;
  localparam int unsigned OP_ADD    = 3;
  localparam int unsigned OP_SUB    = 4;
  localparam int unsigned OP_JMP    = 5;
  localparam int unsigned OP_JMPGEZ = 6;
  localparam int unsigned OP_HALT   = 7;

  // Control-word bit indices; C5 and C10..C15 are reserved and stay low
  localparam int unsigned C0  = 0;   // MAR <- PC
  localparam int unsigned C1  = 1;   // MBR <- mem
  localparam int unsigned C2  = 2;   // PC  <- PC + 1
  localparam int unsigned C3  = 3;   // IR  <- MBR
  localparam int unsigned C4  = 4;   // MAR <- IR.addr
  localparam int unsigned C5  = 5;
  localparam int unsigned C6  = 6;   // BR  <- MBR (ALU X load)
  localparam int unsigned C7  = 7;   // ACC <- ALU
  localparam int unsigned C8  = 8;   // MBR <- ACC
  localparam int unsigned C9  = 9;   // PC  <- IR.addr
  localparam int unsigned C10 = 10;
  localparam int unsigned C11 = 11;
  localparam int unsigned C12 = 12;
  localparam int unsigned C13 = 13;
  localparam int unsigned C14 = 14;
  localparam int unsigned C15 = 15;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_LOAD,
    CLS_STORE,
    CLS_ADD,
    CLS_SUB,
    CLS_JMP,
    CLS_JMPGEZ,
    CLS_HALT
  } cls_t;

  // One-hot mask for a control bit
  function automatic logic [CW_MAX-1:0] cbit(input int unsigned idx);
    return CW_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/ctrl_seq_op_decode.sv
// Combinational instruction classifier: opcode -> instruction class, plus
// jump-taken qualification from the accumulator sign.
module op_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 8
) (
  input  logic [OPW-1:0] i_op,
  input  logic           i_acc_neg,
  output logic [2:0]     o_cls,
  output logic           o_jmp_taken
);

  always_comb begin
    o_cls       = CLS_NOP;
    o_jmp_taken = 1'b0;
    case (i_op)
      OPW'(OP_LOAD):   o_cls = CLS_LOAD;
      OPW'(OP_STORE):  o_cls = CLS_STORE;
      OPW'(OP_ADD):    o_cls = CLS_ADD;
      OPW'(OP_SUB):    o_cls = CLS_SUB;
      OPW'(OP_JMP): begin
        o_cls       = CLS_JMP;
        o_jmp_taken = 1'b1;
      end
      OPW'(OP_JMPGEZ): begin
        o_cls       = CLS_JMPGEZ;
        o_jmp_taken = !i_acc_neg;
      end
      OPW'(OP_HALT):   o_cls = CLS_HALT;
      default:         o_cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Hardwired instruction-cycle sequencer. Each state's micro-step is registered
// on the edge that leaves it, so ctrl shows a state's control bits one cycle later.
module ctrl_seq
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 8,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] ir_op,
  input  logic           acc_neg,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic [CW-1:0]  ctrl,
  output logic [1:0]     alu_op,
  output logic           halted
);

  state_t          r_state;
  logic [2:0]      r_cls;
  logic [CW-1:0]   r_ctrl;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [1:0]      r_alu_op;
  logic            r_halted;

  logic [2:0]      w_cls;
  logic            w_jmp_taken;

  function automatic logic [CW-1:0] cw_of(input logic [CW_MAX-1:0] m);
    return CW'(m);
  endfunction

  op_decode #(
    .OPW (OPW)
  ) u_op_decode (
    .i_op        (ir_op),
    .i_acc_neg   (acc_neg),
    .o_cls       (w_cls),
    .o_jmp_taken (w_jmp_taken)
  );

  // Sequencer: control pulses default low every cycle; mem_req spans F2/E2 only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cls     <= CLS_NOP;
      r_ctrl    <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_alu_op  <= ALU_PASS;
      r_halted  <= 1'b0;
    end else begin
      r_ctrl   <= '0;
      r_alu_op <= ALU_PASS;
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_F1;
        end
        ST_F1: begin
          r_ctrl    <= cw_of(cbit(C0));
          r_mem_req <= 1'b1;
          r_mem_we  <= 1'b0;
          r_state   <= ST_F2;
        end
        ST_F2: begin
          if (mem_ack) begin
            r_ctrl    <= cw_of(cbit(C1));
            r_mem_req <= 1'b0;
            r_state   <= ST_F3;
          end
        end
        ST_F3: begin
          r_ctrl  <= cw_of(cbit(C2) | cbit(C3));
          r_state <= ST_DEC;
        end
        ST_DEC: begin
          r_cls <= w_cls;
          case (w_cls)
            CLS_LOAD, CLS_STORE, CLS_ADD, CLS_SUB: r_state <= ST_E1;
            CLS_JMP, CLS_JMPGEZ: begin
              if (w_jmp_taken) r_ctrl <= cw_of(cbit(C9));
              r_state <= ST_F1;
            end
            CLS_HALT: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
            default: r_state <= ST_F1;
          endcase
        end
        ST_E1: begin
          if (r_cls == CLS_STORE) r_ctrl <= cw_of(cbit(C4) | cbit(C8));
          else                    r_ctrl <= cw_of(cbit(C4));
          r_mem_req <= 1'b1;
          r_mem_we  <= (r_cls == CLS_STORE);
          r_state   <= ST_E2;
        end
        ST_E2: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_cls == CLS_STORE) begin
              r_state <= ST_F1;
            end else begin
              r_ctrl  <= cw_of(cbit(C1));
              r_state <= ST_E3;
            end
          end
        end
        ST_E3: begin
          // C6 lasts exactly one cycle so the negedge-sampled BR loads once
          r_ctrl <= cw_of(cbit(C6) | cbit(C7));
          case (r_cls)
            CLS_ADD: r_alu_op <= ALU_ADD;
            CLS_SUB: r_alu_op <= ALU_SUB;
            default: r_alu_op <= ALU_PASS;
          endcase
          r_state <= ST_F1;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req = r_mem_req;
  assign mem_we  = r_mem_we;
  assign ctrl    = r_ctrl;
  assign alu_op  = r_alu_op;
  assign halted  = r_halted;

endmodule
